// File: rtl/pea_pkg.sv
// rtl/pea_pkg.sv - shared constants and types for the PE array control path
package pea_pkg;

    localparam int CTRL_W  = 13;
    localparam int OPC_LSB = 0;
    localparam int OP2_LSB = 4;
    localparam int OP1_LSB = 7;
    localparam int OUT_LSB = 10;
    localparam int PE_LAT  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pea_latency_tracker.sv
// rtl/pea_latency_tracker.sv - shadow pipeline of issued ops, checks each retires after LAT cycles
module pea_latency_tracker #(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    input  logic check,
    input  logic retire,
    output logic mismatch,
    output logic empty
);

    logic [LAT-1:0] sh;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh <= '0;
        end else begin
            sh <= {sh[LAT-2:0], issue};
        end
    end

    assign mismatch = check && (sh[LAT-1] != retire);

    // The tap retires this cycle, so only younger stages and a new issue keep work in flight.
    assign empty = !issue && (sh[LAT-2:0] == '0);

endmodule

// File: rtl/pe_ctrl_sequencer.sv
// rtl/pe_ctrl_sequencer.sv - replays a context program of PE control words and tracks their retirement
module pe_ctrl_sequencer #(
    parameter int DEPTH  = 16,
    parameter int CTRL_W = pea_pkg::CTRL_W,
    parameter int PE_LAT = pea_pkg::PE_LAT,
    parameter int LOOP_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic [CTRL_W-1:0]          cfg_data,
    input  logic [$clog2(DEPTH):0]     cfg_len,
    input  logic [LOOP_W-1:0]          loop_cnt,
    input  logic                       start,
    input  logic                       data_valid,
    input  logic                       pe_output_ready,
    output logic [CTRL_W-1:0]          ctrl,
    output logic                       en,
    output logic                       input_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [15:0]                issued
);

    import pea_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]       LEN_ONE  = (AW+1)'(1);
    localparam logic [LOOP_W-1:0] LOOP_ONE = LOOP_W'(1);

    seq_state_t        state;
    logic [CTRL_W-1:0] ctx [DEPTH];
    logic [AW-1:0]     pc;
    logic [AW:0]       len;
    logic [LOOP_W-1:0] reps;
    logic              last_word;
    logic              mismatch;
    logic              empty;

    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign last_word = ({1'b0, pc} == len - LEN_ONE);

    // The program must not change underneath a running replay.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            ctx[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            len         <= '0;
            reps        <= '0;
            ctrl        <= '0;
            en          <= 1'b0;
            input_ready <= 1'b0;
            issued      <= '0;
            err         <= 1'b0;
        end else begin
            en          <= 1'b0;
            input_ready <= 1'b0;
            if (mismatch) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        len    <= cfg_len;
                        reps   <= (loop_cnt == '0) ? LOOP_ONE : loop_cnt;
                        pc     <= '0;
                        issued <= '0;
                        err    <= 1'b0;
                        state  <= (cfg_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (data_valid) begin
                        ctrl        <= ctx[pc];
                        en          <= 1'b1;
                        input_ready <= 1'b1;
                        if (issued != 16'hFFFF) begin
                            issued <= issued + 16'd1;
                        end
                        if (last_word) begin
                            pc   <= '0;
                            reps <= reps - LOOP_ONE;
                            if (reps == LOOP_ONE) begin
                                state <= DRAIN;
                            end
                        end else begin
                            pc <= pc + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Retirement is only policed while a run owns the PE; abandoned results are ignored.
    pea_latency_tracker #(
        .LAT (PE_LAT)
    ) u_lat (
        .clk      (clk),
        .reset    (reset),
        .issue    (en),
        .check    (busy),
        .retire   (pe_output_ready),
        .mismatch (mismatch),
        .empty    (empty)
    );

endmodule

// File: doc/pe_ctrl_sequencer.md
# pe_ctrl_sequencer

Upstream issue stage for one `PE_basic` tile.
- Holds a small context memory of 13-bit PE control words, replays them as a timed program into the PE, and drives the PE's `ctrl`, `en` and `input_ready` inputs.
- Tracks the PE's fixed 3-cycle floating-point latency with an in-flight shadow pipeline, and checks that every issued operation retires on `output_ready`.
- Reports completion, so the array controller can chain PE programs without counting cycles itself.

## Interface
Parameters:
- `DEPTH`, 16: context words; power of two.
- `CTRL_W`, 13: PE control word width, `{out[2:0], op1[2:0], op2[2:0], opcode[3:0]}`.
- `PE_LAT`, 3: PE issue-to-result latency in cycles.
- `LOOP_W`, 8: width of the repeat counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  context write strobe.
- `cfg_addr`  in  $clog2(DEPTH)  write address.
- `cfg_data`  in  CTRL_W  control word to store.
- `cfg_len`  in  $clog2(DEPTH)+1  program length in words, 0..DEPTH.
- `loop_cnt`  in  LOOP_W  program repetitions; 0 is treated as 1.
- `start`  in  1  start pulse; sampled only in IDLE.
- `data_valid`  in  1  upstream operands on E/S/W/N are valid this cycle.
- `pe_output_ready`  in  1  PE `output_ready`.
- `ctrl`  out  CTRL_W  to PE `ctrl`.
- `en`  out  1  to PE `en`.
- `input_ready`  out  1  to PE `input_ready`.
- `busy`  out  1  high from RUN through DRAIN.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky latency mismatch; cleared by `reset` or `start`.
- `issued`  out  16  operations issued this run.

## Operation
- Context RAM:
  - `cfg_we` writes `cfg_data` to `cfg_addr` on the edge.
  - Writes while `busy` are ignored.
  - RAM contents are not reset.
- `start` in IDLE latches `cfg_len` and `loop_cnt`, clears `pc`, `issued` and `err`.
- States and transitions:
  - IDLE → RUN on `start` with `cfg_len`≠0.
  - IDLE → DONE on `start` with `cfg_len`=0.
  - RUN → DRAIN after the final word of the final repetition is issued.
  - DRAIN → DONE when the in-flight shadow pipeline is all zero.
  - DONE → IDLE unconditionally.
- RUN, `data_valid`=1: next cycle drives `ctrl`=ctx[`pc`], `en`=1, `input_ready`=1.
  - `pc` increments.
  - At `pc`=len−1, `pc` wraps to 0 and the repetition counter decrements.
  - `issued` increments, saturating at 16'hFFFF.
- RUN, `data_valid`=0: next cycle drives `en`=0 and `input_ready`=0, holds `ctrl`, and `pc` does not advance.
- Shadow pipeline (PE_LAT bits):
  - Bit 0 is loaded with the `en` value presented to the PE each cycle.
  - Each cycle the tap is compared to `pe_output_ready`; any mismatch sets `err`.
- `start` outside IDLE is ignored.
- `reset` mid-run: immediate return to IDLE; the shadow pipeline and all outputs clear; in-flight PE results are abandoned and never flagged.

## Timing
- Reset values:
  - `ctrl`=0, `en`=0, `input_ready`=0, `busy`=0, `done`=0, `err`=0, `issued`=0.
  - State IDLE, `pc`=0.
- `ctrl`, `en`, `input_ready` are registered. An issue decision made in cycle t appears at the PE in t+1.
- `start` at edge t: `busy`=1 from t+1, and the first word can appear at t+2.
- `pe_output_ready` is expected high exactly PE_LAT cycles after the cycle in which `en`=1 was presented.
- With continuous `data_valid`, the final issue is at cycle t, `done` pulses at t+PE_LAT+1, and `busy` falls in the same cycle `done` rises.
- `cfg_len`=0: `done` at t+1, `busy` never rises, nothing is issued.
- `loop_cnt`=0 behaves identically to `loop_cnt`=1.
- `cfg_len`=DEPTH: all words issue and `pc` wraps 15→0.

## Structure
- Shared package `pea_pkg`:
  - `CTRL_W`.
  - Field offsets `OPC_LSB`=0, `OP2_LSB`=4, `OP1_LSB`=7, `OUT_LSB`=10.
  - `PE_LAT`.
  - State enum `seq_state_t` {IDLE, RUN, DRAIN, DONE}.
- One sub-module: `pea_latency_tracker`, the PE_LAT-deep shadow shift register with mismatch compare and `empty` flag. The PE's output stage reuses it.

## Test plan
- Load ctx[0..3]=13'h0010,13'h0211,13'h0412,13'h0613; len 4, loop 1; `data_valid` held 1; PE model asserts `output_ready` 3 cycles after each `en` → `ctrl` sequence matches on 4 consecutive cycles, `issued`=4, `done` pulses 4 cycles after the last issue, `err`=0.
- Same program, `data_valid` low on the 2nd and 3rd cycles → `en`=0 gaps in the same cycles, word order unchanged, `err`=0.
- len 2, loop 3 → 6 issues in order 0,1,0,1,0,1; `issued`=6.
- PE model drops one `output_ready` → `err`=1 on the expected cycle and stays 1 until the next `start`.
- len 0 `start` → `done` next cycle, `en` never high. Then `reset` asserted 2 cycles into a len-4 run → all outputs 0 on the next cycle, state IDLE, late `output_ready` does not set `err`.
